idx_arbiter: RTL and testbench

Round-robin arbiter that shares the 3-stage idx delay pipeline between N_REQ requesters. Each cycle it grants at most one requester, forwards that requester's index to the pipeline input, and tracks ownership in a shadow pipeline. As a result, every word leaving the pipeline is returned tagged with the requester that issued it. It sits directly in front of the delay pipeline, and its response outputs are cycle-aligned with the pipeline's idx_dd output.

---
 rtl/idx_arbiter.sv | 107 ++++++++++
 tb/tb_idx_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/idx_arbiter.sv
// Round-robin arbiter with burst limit in front of the idx delay pipeline.
// A shadow shift register tags each word leaving the pipeline with its owner.
module idx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = 4,
  parameter int PIPE_LAT = 3,
  parameter int BURST    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               en_mask,
  input  logic [N_REQ*IDX_W-1:0]         idx_in,
  output logic [N_REQ-1:0]               gnt,
  output logic [IDX_W-1:0]               idx_out,
  output logic                           resp_valid,
  output logic [$clog2(N_REQ)-1:0]       resp_id,
  output logic [$clog2(PIPE_LAT+1)-1:0]  inflight
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(PIPE_LAT+1);
  localparam int BC_W  = $clog2(BURST+1);

  logic [ID_W-1:0]     r_owner;
  logic [BC_W-1:0]     r_burst;
  logic [PIPE_LAT-1:0] r_v_sr;
  logic [ID_W-1:0]     r_id_sr [PIPE_LAT];
  logic [CNT_W-1:0]    r_inflight;

  logic [N_REQ-1:0]    w_elig;
  logic                w_grant_vld;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W-1:0]     w_owner_next;
  logic [BC_W-1:0]     w_burst_next;
  logic [N_REQ-1:0]    w_gnt;
  logic [PIPE_LAT-1:0] w_v_next;
  logic [CNT_W-1:0]    w_cnt_next;

  // Grant selection: repeat within burst, else rotate scanning owner+1 .. owner.
  always_comb begin
    w_elig       = req & en_mask;
    w_grant_vld  = 1'b0;
    w_grant_id   = '0;
    w_owner_next = r_owner;
    w_burst_next = '0;
    if (!reset && (|w_elig)) begin
      w_grant_vld = 1'b1;
      if (w_elig[r_owner] && (r_burst != '0) && (r_burst < BC_W'(BURST))) begin
        w_grant_id   = r_owner;
        w_burst_next = r_burst + BC_W'(1);
      end else begin
        // Descending scan so the closest eligible id after owner wins last.
        for (int k = N_REQ; k >= 1; k--) begin
          if (w_elig[(int'(r_owner) + k) % N_REQ])
            w_grant_id = ID_W'((int'(r_owner) + k) % N_REQ);
        end
        w_owner_next = w_grant_id;
        w_burst_next = BC_W'(1);
      end
    end
  end

  always_comb begin
    w_gnt   = '0;
    idx_out = '0;
    if (w_grant_vld) begin
      w_gnt[w_grant_id] = 1'b1;
      idx_out = idx_in[int'(w_grant_id)*IDX_W +: IDX_W];
    end
  end

  assign gnt = w_gnt;

  always_comb begin
    w_v_next    = '0;
    w_v_next[0] = w_grant_vld;
    for (int i = 1; i < PIPE_LAT; i++)
      w_v_next[i] = r_v_sr[i-1];
    w_cnt_next = '0;
    for (int i = 0; i < PIPE_LAT; i++)
      w_cnt_next = w_cnt_next + CNT_W'(w_v_next[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= ID_W'(N_REQ-1);
      r_burst    <= '0;
      r_v_sr     <= '0;
      r_inflight <= '0;
      for (int i = 0; i < PIPE_LAT; i++)
        r_id_sr[i] <= '0;
    end else begin
      r_owner    <= w_owner_next;
      r_burst    <= w_burst_next;
      r_v_sr     <= w_v_next;
      r_inflight <= w_cnt_next;
      r_id_sr[0] <= w_grant_vld ? w_grant_id : '0;
      for (int i = 1; i < PIPE_LAT; i++)
        r_id_sr[i] <= r_id_sr[i-1];
    end
  end

  assign resp_valid = r_v_sr[PIPE_LAT-1];
  assign resp_id    = r_id_sr[PIPE_LAT-1];
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_idx_arbiter.sv
// Directed table-driven bench for idx_arbiter (BURST=2 main instance,
// BURST=1 instance for lone-requester and pure round-robin behaviour).
module tb_idx_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, en_mask, req1, en1;
  logic [15:0] idx_in;
  logic [3:0]  gnt, gnt1, idx_out, idx_out1;
  logic        resp_valid, resp_valid1;
  logic [1:0]  resp_id, resp_id1, inflight, inflight1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  idx_arbiter #(.N_REQ(4), .IDX_W(4), .PIPE_LAT(3), .BURST(2)) dut (
    .clk(clk), .reset(reset), .req(req), .en_mask(en_mask), .idx_in(idx_in),
    .gnt(gnt), .idx_out(idx_out), .resp_valid(resp_valid), .resp_id(resp_id),
    .inflight(inflight)
  );

  idx_arbiter #(.N_REQ(4), .IDX_W(4), .PIPE_LAT(3), .BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .en_mask(en1), .idx_in(idx_in),
    .gnt(gnt1), .idx_out(idx_out1), .resp_valid(resp_valid1), .resp_id(resp_id1),
    .inflight(inflight1)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic [3:0] gnt;
    logic [3:0] idx;
    logic       rv;
    logic [1:0] rid;
    logic [1:0] inf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  initial begin
    // Contention 0,0,1,1,2,2,3,3,0,0 then masking, idle gaps, lone requester.
    tbl.push_back('{4'b1111, 4'b1111, 4'b0001, 4'd1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0001, 4'd1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0010, 4'd2, 1'b0, 2'd0, 2'd2});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0010, 4'd2, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0100, 4'd3, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0100, 4'd3, 1'b1, 2'd1, 2'd3});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1000, 4'd4, 1'b1, 2'd1, 2'd3});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1000, 4'd4, 1'b1, 2'd2, 2'd3});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0001, 4'd1, 1'b1, 2'd2, 2'd3});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0001, 4'd1, 1'b1, 2'd3, 2'd3});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0010, 4'd2, 1'b1, 2'd3, 2'd3});
    tbl.push_back('{4'b1111, 4'b1001, 4'b1000, 4'd4, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{4'b1111, 4'b1011, 4'b1000, 4'd4, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{4'b1111, 4'b1011, 4'b0001, 4'd1, 1'b1, 2'd1, 2'd3});
    tbl.push_back('{4'b1111, 4'b1011, 4'b0001, 4'd1, 1'b1, 2'd3, 2'd3});
    tbl.push_back('{4'b1111, 4'b1011, 4'b0010, 4'd2, 1'b1, 2'd3, 2'd3});
    tbl.push_back('{4'b0100, 4'b1111, 4'b0100, 4'd3, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{4'b0000, 4'b1111, 4'b0000, 4'd0, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{4'b0000, 4'b1111, 4'b0000, 4'd0, 1'b1, 2'd1, 2'd2});
    tbl.push_back('{4'b0001, 4'b1111, 4'b0001, 4'd1, 1'b1, 2'd2, 2'd1});
    tbl.push_back('{4'b0000, 4'b1111, 4'b0000, 4'd0, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{4'b0000, 4'b1111, 4'b0000, 4'd0, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{4'b0000, 4'b1111, 4'b0000, 4'd0, 1'b1, 2'd0, 2'd1});
    tbl.push_back('{4'b0000, 4'b1111, 4'b0000, 4'd0, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{4'b0001, 4'b1111, 4'b0001, 4'd1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{4'b0001, 4'b1111, 4'b0001, 4'd1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{4'b0001, 4'b1111, 4'b0001, 4'd1, 1'b0, 2'd0, 2'd2});
    tbl.push_back('{4'b0001, 4'b1111, 4'b0001, 4'd1, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{4'b0001, 4'b1111, 4'b0001, 4'd1, 1'b1, 2'd0, 2'd3});

    reset   = 1'b1;
    req     = '0;
    en_mask = '0;
    req1    = '0;
    en1     = '0;
    idx_in  = {4'd4, 4'd3, 4'd2, 4'd1};
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < tbl.size(); v++) begin
      req     = tbl[v].req;
      en_mask = tbl[v].en;
      #1;
      chk($sformatf("vec%0d.gnt", v),        int'(gnt),        int'(tbl[v].gnt));
      chk($sformatf("vec%0d.idx_out", v),    int'(idx_out),    int'(tbl[v].idx));
      chk($sformatf("vec%0d.resp_valid", v), int'(resp_valid), int'(tbl[v].rv));
      chk($sformatf("vec%0d.resp_id", v),    int'(resp_id),    int'(tbl[v].rid));
      chk($sformatf("vec%0d.inflight", v),   int'(inflight),   int'(tbl[v].inf));
      $display("vec %0d req=%b en=%b gnt=%b idx=%0d rv=%0b rid=%0d inf=%0d",
               v, req, en_mask, gnt, idx_out, resp_valid, resp_id, inflight);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream with a full shadow pipeline.
    req     = 4'b1111;
    en_mask = 4'b1111;
    repeat (3) @(negedge clk);
    chk("pre_reset.inflight", int'(inflight), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_reset.gnt",        int'(gnt),        0);
    chk("async_reset.idx_out",    int'(idx_out),    0);
    chk("async_reset.resp_valid", int'(resp_valid), 0);
    chk("async_reset.resp_id",    int'(resp_id),    0);
    chk("async_reset.inflight",   int'(inflight),   0);
    $display("async reset gnt=%b rv=%0b inf=%0d", gnt, resp_valid, inflight);
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("post_reset%0d.resp_valid", c), int'(resp_valid), 0);
      chk($sformatf("post_reset%0d.inflight", c),   int'(inflight),   0);
      $display("post reset cycle %0d rv=%0b inf=%0d", c, resp_valid, inflight);
      @(negedge clk);
    end
    req = 4'b0001;
    #1;
    chk("first_after_reset.gnt", int'(gnt), 1);
    $display("first grant after reset gnt=%b", gnt);
    @(negedge clk);
    req = '0;

    // BURST=1: lone requester is re-granted every cycle, then plain round-robin.
    req1 = 4'b0010;
    en1  = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("b1_lone%0d.gnt", c),     int'(gnt1),     2);
      chk($sformatf("b1_lone%0d.idx_out", c), int'(idx_out1), 2);
      chk($sformatf("b1_lone%0d.resp_valid", c), int'(resp_valid1), (c >= 3) ? 1 : 0);
      $display("b1 lone cycle %0d gnt=%b rv=%0b rid=%0d", c, gnt1, resp_valid1, resp_id1);
      @(negedge clk);
    end
    req1 = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      int exp_id;
      exp_id = (2 + c) % 4;
      #1;
      chk($sformatf("b1_rr%0d.gnt", c), int'(gnt1), 1 << exp_id);
      $display("b1 rr cycle %0d gnt=%b", c, gnt1);
      @(negedge clk);
    end
    req1 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
